// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution output-channel scheduler.
package conv_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_WEIGHT_WIDTH = 8;
    localparam int DEFAULT_OUTPUT_WIDTH = 20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        CALC  = 3'd3,
        OUT   = 3'd4
    } state_t;

    function automatic int win_width(input int in_ch, input int k, input int dw);
        return in_ch * k * k * dw;
    endfunction

    function automatic int wt_width(input int in_ch, input int k, input int ww);
        return in_ch * k * k * ww;
    endfunction

endpackage

// File: rtl/conv_oc_scheduler.sv
// Walks one latched input window through every output-channel filter of a combinational MAC.
// Optional perf counters (stall cycles, completed windows) are enabled with CONV_OC_SCHED_PERF_EN.
module conv_oc_scheduler
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH,
    parameter int KERNEL_SIZE  = 3,
    parameter int IN_CHANNEL   = 3,
    parameter int OUT_CHANNEL  = 4,
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
    parameter int OC_WIDTH     = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1,
    localparam int WIN_W       = win_width(IN_CHANNEL, KERNEL_SIZE, DATA_WIDTH),
    localparam int WT_W        = wt_width(IN_CHANNEL, KERNEL_SIZE, WEIGHT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [WIN_W-1:0]        win_data,
    output logic                    wt_rd_en,
    output logic [OC_WIDTH-1:0]     wt_rd_addr,
    input  logic [WT_W-1:0]         wt_rd_data,
    output logic [WIN_W-1:0]        mac_window,
    output logic                    mac_window_valid,
    output logic [WT_W-1:0]         mac_weight,
    output logic                    mac_weight_valid,
    input  logic [OUTPUT_WIDTH-1:0] mac_conv_out,
    input  logic                    mac_conv_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic [OC_WIDTH-1:0]     out_ch,
    output logic                    out_last,
    output logic                    busy,
    output logic [2:0]              dbg_state
`ifdef CONV_OC_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_win_cnt
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // source holds data stable while valid is high and ready is low.

    localparam logic [OC_WIDTH-1:0] LAST_OC = OC_WIDTH'(OUT_CHANNEL - 1);

    state_t              state;
    logic [OC_WIDTH-1:0] oc;
    logic [WIN_W-1:0]    win_reg;
    logic [WT_W-1:0]     wt_reg;

    assign win_ready  = (state == IDLE);
    assign mac_window = win_reg;
    assign mac_weight = wt_reg;
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            oc               <= '0;
            win_reg          <= '0;
            wt_reg           <= '0;
            wt_rd_en         <= 1'b0;
            wt_rd_addr       <= '0;
            mac_window_valid <= 1'b0;
            mac_weight_valid <= 1'b0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_ch           <= '0;
            out_last         <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        win_reg    <= win_data;
                        oc         <= '0;
                        wt_rd_addr <= '0;
                        wt_rd_en   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    wt_rd_en <= 1'b0;
                    state    <= WAIT;
                end
                // Memory data arrives one cycle after the strobe, so it is captured here.
                WAIT: begin
                    wt_reg           <= wt_rd_data;
                    mac_window_valid <= 1'b1;
                    mac_weight_valid <= 1'b1;
                    state            <= CALC;
                end
                CALC: begin
                    out_data         <= mac_conv_out;
                    out_ch           <= oc;
                    out_last         <= (oc == LAST_OC);
                    mac_window_valid <= 1'b0;
                    mac_weight_valid <= 1'b0;
                    out_valid        <= 1'b1;
                    state            <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            oc         <= oc + 1'b1;
                            wt_rd_addr <= oc + 1'b1;
                            wt_rd_en   <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    wt_rd_en  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONV_OC_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_win_cnt   <= '0;
        end else begin
            if (out_valid && !out_ready && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (out_valid && out_ready && out_last && perf_win_cnt != 32'hFFFF_FFFF) begin
                perf_win_cnt <= perf_win_cnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // The MAC is combinational, so its valid must already be up while CALC samples it.
    always_ff @(posedge clk) begin
        if (!rst && state == CALC) begin
            assert (mac_conv_valid)
            else $error("conv_oc_scheduler: mac_conv_valid low in CALC");
        end
    end
`endif

endmodule

// File: tb/tb_conv_oc_scheduler.sv
// Directed bench for conv_oc_scheduler with a behavioural saturating MAC and 1-cycle weight memory.
module tb_conv_oc_scheduler;

    localparam int WIN_W = 216;
    localparam int WT_W  = 216;
    localparam int OW    = 20;
    localparam int OCW   = 2;
    localparam int BW    = 1 + OCW + OW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (OUT_CHANNEL = 4) ----------------
    logic             win_valid, win_ready;
    logic [WIN_W-1:0] win_data;
    logic             wt_rd_en;
    logic [OCW-1:0]   wt_rd_addr;
    logic [WT_W-1:0]  wt_rd_data;
    logic [WIN_W-1:0] mac_window;
    logic [WT_W-1:0]  mac_weight;
    logic             mac_window_valid, mac_weight_valid;
    logic [OW-1:0]    mac_conv_out;
    logic             mac_conv_valid;
    logic             out_valid, out_ready, out_last, busy;
    logic [OW-1:0]    out_data;
    logic [OCW-1:0]   out_ch;
    logic [2:0]       dbg_state;
`ifdef CONV_OC_SCHED_PERF_EN
    logic [31:0]      perf_stall_cnt, perf_win_cnt;
    logic [31:0]      perf_stall_cnt1, perf_win_cnt1;
`endif

    // ---------------- DUT (OUT_CHANNEL = 1) ----------------
    logic             win_valid1, win_ready1;
    logic [WIN_W-1:0] win_data1;
    logic             wt_rd_en1;
    logic [0:0]       wt_rd_addr1;
    logic [WT_W-1:0]  wt_rd_data1;
    logic [WIN_W-1:0] mac_window1;
    logic [WT_W-1:0]  mac_weight1;
    logic             mac_window_valid1, mac_weight_valid1;
    logic [OW-1:0]    mac_conv_out1;
    logic             mac_conv_valid1;
    logic             out_valid1, out_ready1, out_last1, busy1;
    logic [OW-1:0]    out_data1;
    logic [0:0]       out_ch1;
    logic [2:0]       dbg_state1;

    logic [WT_W-1:0]  wmem [4];
    logic [WT_W-1:0]  wmem1;

    logic [BW-1:0]    exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    conv_oc_scheduler dut (
        .clk(clk), .rst(rst),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .mac_window(mac_window), .mac_window_valid(mac_window_valid),
        .mac_weight(mac_weight), .mac_weight_valid(mac_weight_valid),
        .mac_conv_out(mac_conv_out), .mac_conv_valid(mac_conv_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
`ifdef CONV_OC_SCHED_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_win_cnt(perf_win_cnt)
`endif
    );

    conv_oc_scheduler #(.OUT_CHANNEL(1)) dut1 (
        .clk(clk), .rst(rst),
        .win_valid(win_valid1), .win_ready(win_ready1), .win_data(win_data1),
        .wt_rd_en(wt_rd_en1), .wt_rd_addr(wt_rd_addr1), .wt_rd_data(wt_rd_data1),
        .mac_window(mac_window1), .mac_window_valid(mac_window_valid1),
        .mac_weight(mac_weight1), .mac_weight_valid(mac_weight_valid1),
        .mac_conv_out(mac_conv_out1), .mac_conv_valid(mac_conv_valid1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_ch(out_ch1), .out_last(out_last1), .busy(busy1), .dbg_state(dbg_state1)
`ifdef CONV_OC_SCHED_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt1), .perf_win_cnt(perf_win_cnt1)
`endif
    );

    // ---------------- MAC and weight memory models ----------------
    function automatic logic [OW-1:0] mac_model(input logic [WIN_W-1:0] w, input logic [WT_W-1:0] k);
        longint acc;
        acc = 0;
        for (int i = 0; i < 27; i++) acc += longint'(w[i*8 +: 8]) * longint'(k[i*8 +: 8]);
        return (acc > 64'd1048575) ? 20'hFFFFF : acc[19:0];
    endfunction

    function automatic logic [WIN_W-1:0] fill(input logic [7:0] v);
        logic [WIN_W-1:0] r;
        for (int i = 0; i < 27; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    assign mac_conv_out    = mac_model(mac_window, mac_weight);
    assign mac_conv_valid  = mac_window_valid && mac_weight_valid;
    assign mac_conv_out1   = mac_model(mac_window1, mac_weight1);
    assign mac_conv_valid1 = mac_window_valid1 && mac_weight_valid1;

    always @(posedge clk) begin
        if (wt_rd_en)  wt_rd_data  <= wmem[wt_rd_addr];
        if (wt_rd_en1) wt_rd_data1 <= wmem1;
    end

    // ---------------- driver helpers ----------------
    task automatic collect_beat(output bit ok, output int cyc, output logic [BW-1:0] beat);
        ok = 1'b0; cyc = 0; beat = '0;
        while (!ok && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                ok = 1'b1;
                beat = {out_last, out_ch, out_data};
            end
        end
    endtask

    task automatic load_ramp_weights();
        for (int k = 0; k < 4; k++) wmem[k] = fill(8'(k + 1));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, busy, wt_rd_en, mac_window_valid, mac_weight_valid, out_last} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {out_valid, busy, wt_rd_en, mac_window_valid, mac_weight_valid, out_last});
        end
        n_checks++;
        if (out_data !== 20'd0 || out_ch !== 2'd0 || wt_rd_addr !== 2'd0 || mac_window !== '0 || mac_weight !== '0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%h out_ch=%h addr=%h expected all zero", out_data, out_ch, wt_rd_addr);
        end
`ifdef CONV_OC_SCHED_PERF_EN
        n_checks++;
        if (perf_stall_cnt !== 32'd0 || perf_win_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: stall=%0d win=%0d expected 0 0", perf_stall_cnt, perf_win_cnt);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({win_ready, busy, dbg_state, win_ready1, busy1} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected 10000010", {win_ready, busy, dbg_state, win_ready1, busy1});
        end
    endtask

    task automatic test_basic();
        bit ok; int cyc; logic [BW-1:0] beat, exp_b;
        load_ramp_weights();
        out_ready = 1'b1; win_data = fill(8'd1); win_valid = 1'b1;
        n_checks++;
        if (win_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_ready: got %b expected 1", win_ready);
        end
        @(negedge clk);
        win_valid = 1'b0;
        n_checks++;
        if ({busy, wt_rd_en, wt_rd_addr, win_ready} !== 5'b11000) begin
            n_fail++; $display("FAIL basic_fetch: got %b expected 11000", {busy, wt_rd_en, wt_rd_addr, win_ready});
        end
        for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, 2'(k), 20'(27 * (k + 1))});
        for (int k = 0; k < 4; k++) begin
            collect_beat(ok, cyc, beat);
            exp_b = exp_q.pop_front();
            n_checks++;
            if (!ok || beat !== exp_b) begin
                n_fail++; $display("FAIL basic_beat%0d: got %h (seen=%0d) expected %h", k, beat, ok, exp_b);
            end
            // FETCH, WAIT, CALC, OUT: valid is visible in the fourth cycle after accept/handshake.
            n_checks++;
            if (cyc !== ((k == 0) ? 3 : 4)) begin
                n_fail++; $display("FAIL basic_latency%0d: got %0d expected %0d", k, cyc, (k == 0) ? 3 : 4);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({win_ready, busy, out_valid} !== 3'b100) begin
            n_fail++; $display("FAIL basic_idle: got %b expected 100", {win_ready, busy, out_valid});
        end
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; logic [BW-1:0] beat;
`ifdef CONV_OC_SCHED_PERF_EN
        logic [31:0] stall0;
        stall0 = perf_stall_cnt;
`endif
        load_ramp_weights();
        out_ready = 1'b1; win_data = fill(8'd1); win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        collect_beat(ok, cyc, beat);
        n_checks++;
        if (!ok || beat !== {1'b0, 2'd0, 20'd27}) begin
            n_fail++; $display("FAIL bp_beat0: got %h expected %h", beat, {1'b0, 2'd0, 20'd27});
        end
        @(negedge clk);
        out_ready = 1'b0;
        collect_beat(ok, cyc, beat);
        n_checks++;
        if (!ok || beat !== {1'b0, 2'd1, 20'd54}) begin
            n_fail++; $display("FAIL bp_beat1: got %h expected %h", beat, {1'b0, 2'd1, 20'd54});
        end
        for (int i = 0; i <= 10; i++) begin
            n_checks++;
            if ({out_valid, out_last, out_ch, out_data, wt_rd_en} !== {1'b1, 1'b0, 2'd1, 20'd54, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b last=%b ch=%0d data=%0d rd_en=%b expected 1 0 1 54 0",
                         i, out_valid, out_last, out_ch, out_data, wt_rd_en);
            end
            if (i < 10) @(negedge clk);
        end
`ifdef CONV_OC_SCHED_PERF_EN
        n_checks++;
        if (perf_stall_cnt - stall0 !== 32'd10) begin
            n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 10", perf_stall_cnt - stall0);
        end
`endif
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({wt_rd_en, wt_rd_addr, out_valid} !== 4'b1100) begin
            n_fail++; $display("FAIL bp_refetch: got %b expected 1100", {wt_rd_en, wt_rd_addr, out_valid});
        end
        exp_q.push_back({1'b0, 2'd2, 20'd81});
        exp_q.push_back({1'b1, 2'd3, 20'd108});
        while (exp_q.size() > 0) begin
            logic [BW-1:0] exp_b;
            collect_beat(ok, cyc, beat);
            exp_b = exp_q.pop_front();
            n_checks++;
            if (!ok || beat !== exp_b) begin
                n_fail++; $display("FAIL bp_tail: got %h (seen=%0d) expected %h", beat, ok, exp_b);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit ok; int cyc; logic [BW-1:0] beat, exp_b;
        for (int k = 0; k < 4; k++) wmem[k] = fill(8'hFF);
        out_ready = 1'b1; win_data = fill(8'hFF); win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        // 27 * 255 * 255 = 1755675 clips to the 20-bit maximum
        for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, 2'(k), 20'd1048575});
        while (exp_q.size() > 0) begin
            collect_beat(ok, cyc, beat);
            exp_b = exp_q.pop_front();
            n_checks++;
            if (!ok || beat !== exp_b) begin
                n_fail++; $display("FAIL sat_beat: got %h (seen=%0d) expected %h", beat, ok, exp_b);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc; logic [BW-1:0] beat, exp_b;
`ifdef CONV_OC_SCHED_PERF_EN
        logic [31:0] win0;
        win0 = perf_win_cnt;
`endif
        load_ramp_weights();
        out_ready = 1'b1; win_data = fill(8'd1); win_valid = 1'b1;
        @(negedge clk);
        win_data = fill(8'd2);
        n_checks++;
        if (win_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_busy: got %b expected 0", win_ready);
        end
        for (int k = 0; k < 4; k++) begin
            collect_beat(ok, cyc, beat);
            exp_b = {k == 3, 2'(k), 20'(27 * (k + 1))};
            n_checks++;
            if (!ok || beat !== exp_b || win_ready !== 1'b0) begin
                n_fail++; $display("FAIL b2b_first%0d: got %h ready=%b expected %h ready=0", k, beat, win_ready, exp_b);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({win_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_idle: got %b expected 10", {win_ready, busy});
        end
        @(negedge clk);
        win_valid = 1'b0;
        n_checks++;
        if ({win_ready, busy, wt_rd_en} !== 3'b011) begin
            n_fail++; $display("FAIL b2b_accept2: got %b expected 011", {win_ready, busy, wt_rd_en});
        end
        for (int k = 0; k < 4; k++) begin
            collect_beat(ok, cyc, beat);
            exp_b = {k == 3, 2'(k), 20'(54 * (k + 1))};
            n_checks++;
            if (!ok || beat !== exp_b) begin
                n_fail++; $display("FAIL b2b_second%0d: got %h expected %h", k, beat, exp_b);
            end
        end
        @(negedge clk);
`ifdef CONV_OC_SCHED_PERF_EN
        n_checks++;
        if (perf_win_cnt - win0 !== 32'd2) begin
            n_fail++; $display("FAIL b2b_win_cnt: got %0d expected 2", perf_win_cnt - win0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc; logic [BW-1:0] beat, exp_b;
        load_ramp_weights();
        out_ready = 1'b1; win_data = fill(8'd1); win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            collect_beat(ok, cyc, beat);
            exp_b = {1'b0, 2'(k), 20'(27 * (k + 1))};
            n_checks++;
            if (!ok || beat !== exp_b) begin
                n_fail++; $display("FAIL rmid_pre%0d: got %h expected %h", k, beat, exp_b);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dbg_state, mac_window_valid} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL rmid_calc: state=%0d mac_valid=%b expected 3 1", dbg_state, mac_window_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy, wt_rd_en, mac_window_valid, mac_weight_valid, win_ready} !== 6'b000001
            || out_data !== 20'd0 || out_ch !== 2'd0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL rmid_async: ctrl=%b data=%0d ch=%0d state=%0d expected 000001 0 0 0",
                     {out_valid, busy, wt_rd_en, mac_window_valid, mac_weight_valid, win_ready},
                     out_data, out_ch, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({win_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL rmid_release: got %b expected 10", {win_ready, busy});
        end
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            collect_beat(ok, cyc, beat);
            exp_b = {k == 3, 2'(k), 20'(27 * (k + 1))};
            n_checks++;
            if (!ok || beat !== exp_b) begin
                n_fail++; $display("FAIL rmid_restart%0d: got %h expected %h", k, beat, exp_b);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single_oc();
        bit ok; int cyc;
        wmem1 = fill(8'd3);
        out_ready1 = 1'b1;
        for (int w = 0; w < 2; w++) begin
            win_data1 = fill(8'(w + 1)); win_valid1 = 1'b1;
            @(negedge clk);
            win_valid1 = 1'b0;
            ok = 1'b0; cyc = 0;
            while (!ok && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (out_valid1) ok = 1'b1;
            end
            n_checks++;
            if (!ok || {out_last1, out_ch1, out_data1} !== {1'b1, 1'b0, 20'(81 * (w + 1))}) begin
                n_fail++;
                $display("FAIL single_beat%0d: seen=%0d last=%b ch=%0d data=%0d expected 1 0 %0d",
                         w, ok, out_last1, out_ch1, out_data1, 81 * (w + 1));
            end
            @(negedge clk);
            n_checks++;
            if ({win_ready1, busy1, out_valid1} !== 3'b100) begin
                n_fail++; $display("FAIL single_idle%0d: got %b expected 100", w, {win_ready1, busy1, out_valid1});
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        win_valid = 1'b0; win_data = '0; out_ready = 1'b0;
        win_valid1 = 1'b0; win_data1 = '0; out_ready1 = 1'b0;
        wmem1 = '0;
        for (int k = 0; k < 4; k++) wmem[k] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_single_oc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
